// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   - state_t : FSM state encoding (ST_IDLE, ST_RUN, ST_DONE)
//   - DEFAULT_WIDTH : default operand width
//   - clog2() : width of the iteration counter for a given operand width
package mult_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_shift_add_step.sv
// One combinational iteration of the shift-and-add multiplier.
//   a      : accumulator (upper product half plus carry bit), WIDTH+1 bits
//   m      : multiplier shift register (lower product half), WIDTH bits
//   b      : multiplicand, WIDTH bits
//   a_next : accumulator after add and shift
//   m_next : multiplier register after shift
module shift_add_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] m,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] m_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    // a stays below 2^WIDTH between steps, so the sum fits in WIDTH+1 bits.
    sum = a + (m[0] ? {1'b0, b} : '0);
    // Shift across the full 2*WIDTH+1 bit concatenation: the add carry
    // moves down into the accumulator and sum[0] enters the top of m.
    {a_next, m_next} = {sum, m} >> 1;
  end

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle unsigned shift-and-add multiplier, one iteration per clock.
// product = q*b, or q*b + r when the REMAINDER_ADD_EN macro is defined
// (reconstructs a dividend from a divider's {remainder, quotient}).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted whenever not busy (IDLE or DONE)
//   q, b, r       : multiplier, multiplicand, addend (r unused without macro)
//   busy          : high while iterating
//   done          : one-cycle pulse, product valid from this cycle
//   product       : 2*WIDTH-bit result, held until the next done
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mplr_next;
  logic [WIDTH:0]   acc_load;

`ifdef REMAINDER_ADD_EN
  assign acc_load = {1'b0, r};
`else
  // r is deliberately ignored in this build.
  logic unused_r;
  assign unused_r = ^r;
  assign acc_load = '0;
`endif

  shift_add_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a     (acc),
    .m     (mplr),
    .b     (mcand),
    .a_next(acc_next),
    .m_next(mplr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc   <= acc_load;
            mplr  <= q;
            mcand <= b;
            cnt   <= CNT_INIT;
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          // start is ignored here; operands were captured at load.
          acc  <= acc_next;
          mplr <= mplr_next;
          if (cnt == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          // acc[WIDTH] is always zero here: the product cannot overflow.
          product <= {acc[WIDTH-1:0], mplr};
          if (start) begin
            acc   <= acc_load;
            mplr  <= q;
            mcand <= b;
            cnt   <= CNT_INIT;
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
module tb_seq_shift_add_multiplier;

  localparam int W = 4;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   q, b, r;
  logic           busy, done;
  logic [2*W-1:0] product;

  int checks = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q      (q),
    .b      (b),
    .r      (r),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  // Behavioural model: an accepted request yields its product exactly LAT
  // edges later; busy covers the first W cycles after acceptance.
  bit           m_busy, m_done;
  logic [2*W-1:0] m_prod;
  int           age = -1;
  int           m_exp;

  function automatic int expected(input int qq, input int bb, input int rr);
`ifdef REMAINDER_ADD_EN
    return qq * bb + rr;
`else
    return qq * bb;
`endif
  endfunction

  always @(posedge clk) begin
    bit busy_old;
    busy_old = m_busy;
    if (rst) begin
      m_busy = 0; m_done = 0; m_prod = '0; age = -1;
    end else begin
      m_done = 0;
      if (age >= 0) begin
        age++;
        if (age == LAT) begin
          m_done = 1;
          m_prod = m_exp[2*W-1:0];
          age = -1;
        end
      end
      if (start && !busy_old) begin
        m_exp = expected(int'(q), int'(b), int'(r));
        age = 0;
      end
      m_busy = (age >= 0) && (age <= W - 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_done", 32'(done), 32'(m_done));
      check("model_product", 32'(product), 32'(m_prod));
    end
  end

  // Called at the negedge just after the accepting edge; returns edges waited.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done, required done within %0d cycles", LAT);
    end
  endtask

  task automatic op(input string name, input int qq, input int bb, input int rr,
                    input int req);
    int cyc;
    @(negedge clk);
    start = 1; q = W'(qq); b = W'(bb); r = W'(rr);
    @(negedge clk);
    start = 0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({name, "_latency"}, 32'(cyc), 32'(LAT));
    check({name, "_product"}, 32'(product), 32'(req));
  endtask

  initial begin
    int cyc;
    rst = 1; start = 0; q = '0; b = '0; r = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst = 0;

`ifdef REMAINDER_ADD_EN
    op("q4b3r1", 4, 3, 1, 8'h0D);
    op("q15b15r14", 15, 15, 14, 8'hEF);
`else
    op("q4b3r1", 4, 3, 1, 8'h0C);
    op("q15b15r14", 15, 15, 14, 8'hE1);
`endif
    op("q0b9", 0, 9, 0, 8'h00);

    // start during RUN with different operands is ignored
    @(negedge clk);
    start = 1; q = 4'd5; b = 4'd6; r = 4'd0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; q = 4'd9; b = 4'd9;
    @(negedge clk);
    start = 0;
    wait_done(cyc);
    check("ignore_start_latency", 32'(cyc + 2), 32'(LAT));
    check("ignore_start_product", 32'(product), 32'h1E);
    @(negedge clk);
    check("ignore_start_no_restart", 32'(busy), 32'd0);

    // reset in the middle of RUN
    @(negedge clk);
    start = 1; q = 4'd7; b = 4'd7; r = 4'd0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_product", 32'(product), 32'd0);
    op("after_rst", 3, 6, 0, 8'h12);

    // back-to-back: start held through the DONE cycle
    @(negedge clk);
    start = 1; q = 4'd2; b = 4'd7; r = 4'd0;
    @(negedge clk);
    q = 4'd3; b = 4'd5;
    wait_done(cyc);
    start = 0;
    check("b2b_first_latency", 32'(cyc), 32'(LAT));
    check("b2b_first_product", 32'(product), 32'h0E);
    check("b2b_restart_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("b2b_product_held", 32'(product), 32'h0E);
    wait_done(cyc);
    check("b2b_second_latency", 32'(cyc + 1), 32'(LAT));
    check("b2b_second_product", 32'(product), 32'h0F);

    // randomized traffic checked against the model every cycle
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      q = W'($urandom);
      b = W'($urandom);
      r = W'($urandom);
      rst = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    start = 0; rst = 0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
